// File: rtl/cyp_pkg.sv
// rtl/cyp_pkg.sv - shared types and constants for the FX2 slave-FIFO read controller
package cyp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SETUP = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_END   = 3'd5
    } cyp_state_e;

    localparam logic [1:0] FIFOADR_EP2 = 2'd0;
    localparam logic [1:0] FIFOADR_EP4 = 2'd1;
    localparam logic [1:0] FIFOADR_EP6 = 2'd2;
    localparam logic [1:0] FIFOADR_EP8 = 2'd3;

    localparam int DEF_PKT_WORDS = 256;
    localparam int DEF_WAIT_CLKS = 64;

endpackage

// File: rtl/cyp_slave_rd_ctrl_if.sv
// rtl/cyp_slave_rd_ctrl_if.sv - FX2 slave-FIFO pins plus downstream word stream
interface cyp_slave_rd_ctrl_if #(
    parameter int DW     = 16,
    parameter int NUM_EP = 2,
    parameter int FREE_W = 13
);
    logic [NUM_EP-1:0] usb_flag_ne;
    logic [DW-1:0]     usb_fd_i;
    logic [1:0]        usb_fifoaddr;
    logic              usb_slcs;
    logic              usb_slwr;
    logic              usb_sloe;
    logic              usb_slrd;
    logic [FREE_W-1:0] dn_free;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_sop;
    logic [1:0]        m_ep;

    modport master (
        input  usb_flag_ne, usb_fd_i, dn_free,
        output usb_fifoaddr, usb_slcs, usb_slwr, usb_sloe, usb_slrd,
        output m_data, m_valid, m_sop, m_ep
    );

    modport slave (
        output usb_flag_ne, usb_fd_i, dn_free,
        input  usb_fifoaddr, usb_slcs, usb_slwr, usb_sloe, usb_slrd,
        input  m_data, m_valid, m_sop, m_ep
    );
endinterface

// File: rtl/cyp_rr_arb.sv
// rtl/cyp_rr_arb.sv - combinational round-robin picker, scans from last_grant+1
module cyp_rr_arb #(
    parameter int NUM_EP = 2
) (
    input  logic [NUM_EP-1:0] req,
    input  logic [1:0]        last_grant,
    output logic [1:0]        grant,
    output logic              any
);
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int i = 1; i <= NUM_EP; i++) begin
            idx = (int'(last_grant) + i) % NUM_EP;
            if (!any && req[idx]) begin
                grant = 2'(idx);
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cyp_slave_rd_ctrl.sv
// rtl/cyp_slave_rd_ctrl.sv - multi-endpoint FX2 slave-FIFO packet reader
module cyp_slave_rd_ctrl
    import cyp_pkg::*;
#(
    parameter  int DW        = 16,
    parameter  int NUM_EP    = 2,
    parameter  int PKT_WORDS = DEF_PKT_WORDS,
    parameter  int WAIT_CLKS = DEF_WAIT_CLKS,
    parameter  int FREE_W    = 13,
    localparam int CW        = $clog2(PKT_WORDS + 1)
) (
    input  logic                       cyp_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    cyp_slave_rd_ctrl_if.master        bus,
    output logic                       pkt_done,
    output logic [CW-1:0]              pkt_len,
    output logic                       pkt_short,
    output logic                       busy
);
    localparam int             WW        = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;
    localparam logic [CW-1:0]  CNT_FULL  = CW'(PKT_WORDS);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_CLKS - 1);

    cyp_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic [1:0]    grant_q, last_grant, arb_grant;
    logic          arb_any;
    logic [3:0]    flags4;
    logic          flag_g, space_ok, rd_fire;

    // Widen so the 2-bit grant can index the flags for any NUM_EP.
    assign flags4   = 4'(bus.usb_flag_ne);
    assign flag_g   = flags4[grant_q];
    assign space_ok = 32'(bus.dn_free) >= 32'(PKT_WORDS);

    cyp_rr_arb #(.NUM_EP(NUM_EP)) u_arb (
        .req        (bus.usb_flag_ne),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable && (|bus.usb_flag_ne) && space_ok) state_nxt = ST_ARB;
            ST_ARB:   state_nxt = arb_any ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_nxt = ST_WAIT;
            ST_WAIT:  if (wcnt == WAIT_LAST) state_nxt = ST_READ;
            ST_READ: begin
                if (cnt == CNT_FULL)  state_nxt = ST_END;
                else if (!flag_g)     state_nxt = (cnt != '0) ? ST_END : ST_IDLE;
            end
            ST_END:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_fire          = (state == ST_READ) && flag_g && (cnt < CNT_FULL);
        bus.usb_slrd     = !rd_fire;
        bus.usb_sloe     = !(state inside {ST_SETUP, ST_WAIT, ST_READ});
        bus.usb_slcs     = 1'b0;
        bus.usb_slwr     = 1'b1;
        bus.usb_fifoaddr = grant_q;
        busy             = (state != ST_IDLE);
        pkt_done         = (state == ST_END);
        pkt_len          = pkt_done ? cnt : '0;
        pkt_short        = pkt_done && (cnt < CNT_FULL);
    end

    // last_grant starts at NUM_EP-1 so the first scan lands on endpoint 0.
    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            wcnt        <= '0;
            grant_q     <= FIFOADR_EP2;
            last_grant  <= 2'(NUM_EP - 1);
            bus.m_data  <= '0;
            bus.m_valid <= 1'b0;
            bus.m_sop   <= 1'b0;
            bus.m_ep    <= '0;
        end else begin
            bus.m_valid <= rd_fire;
            bus.m_sop   <= rd_fire && (cnt == '0);
            if (rd_fire) begin
                bus.m_data <= bus.usb_fd_i;
                bus.m_ep   <= grant_q;
                cnt        <= cnt + 1'b1;
            end
            case (state)
                ST_ARB:   grant_q <= arb_grant;
                ST_SETUP: begin
                    cnt  <= '0;
                    wcnt <= '0;
                end
                ST_WAIT:  wcnt <= wcnt + 1'b1;
                ST_END:   last_grant <= grant_q;
                default:  ;
            endcase
        end
    end
endmodule
